label_stats: RTL and testbench
==============================

LABEL_STATS -- requirements
Module: label_stats

Interface
REQ-001 Parameter MAX_OBJ, default 8, maximum distinct labels tracked (1..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  in  1  one-cycle pulse; begins a scan (driven from CLE finish rising edge).
REQ-005 sram_a  out  10  label SRAM read address, row*32+col.
REQ-006 sram_q  in  8  label SRAM data, valid one cycle after address is sampled.
REQ-007 obj_valid  out  1  object record present on obj_* outputs.
REQ-008 obj_ready  in  1  consumer accepts record when obj_valid and obj_ready are both 1.
REQ-009 obj_label  out  8  label value of record.
REQ-010 obj_count  out  11  pixel count of record (1..1024).
REQ-011 obj_xmin/obj_xmax/obj_ymin/obj_ymax  out  5 each  bounding box; x = column, y = row.
REQ-012 busy  out  1  high from accepted start until done.
REQ-013 done  out  1  high after last record is accepted; held until next accepted start.
REQ-014 overflow  out  1  high if more than MAX_OBJ distinct non-zero labels were seen in the current scan.

Function
REQ-015 States IDLE, SCAN, TAIL, EMIT, DONE; start is accepted only in IDLE or DONE, ignored elsewhere.
REQ-016 Accepted start: clear table, overflow and done; set busy; go to SCAN with sram_a=0.
REQ-017 SCAN: sram_a increments by 1 every cycle from 0 to 1023; after issuing 1023 go to TAIL for one cycle to consume the last read.
REQ-018 Read data is paired with a one-cycle-delayed copy of the address (row=addr[9:5], col=addr[4:0]).
REQ-019 Label 0 is background and is not counted.
REQ-020 Non-zero label matching a valid entry: count+1; xmin/xmax/ymin/ymax updated by min/max with the pixel coordinate, same cycle.
REQ-021 Non-zero label with no match and fewer than MAX_OBJ entries: allocate next entry in first-seen order with count=1, box = pixel coordinate.
REQ-022 Non-zero label with no match and table full: pixel dropped, overflow set to 1 (sticky for the scan).
REQ-023 Throughput is one pixel per cycle; an update is visible to the immediately following pixel.
REQ-024 Scan latency: start accepted at cycle 0 -> EMIT or DONE entered at cycle 1026.
REQ-025 EMIT: present entries in allocation order; obj_* stable while obj_valid and not obj_ready; advance one entry per handshake cycle; back-to-back handshakes are allowed.
REQ-026 After the last handshake: obj_valid=0, busy=0, done=1, state DONE; zero entries go straight from TAIL to DONE.
REQ-027 obj_ready is ignored while obj_valid=0.
REQ-028 sram_a holds its last value outside SCAN; the block never writes the SRAM.

Reset
REQ-029 While reset=0: state IDLE, sram_a=0, obj_valid=0, obj_* =0, busy=0, done=0, overflow=0, table entries invalid.
REQ-030 Reset asserted mid-SCAN or mid-EMIT aborts immediately; no partial record is emitted after release.
REQ-031 The first start after reset release is accepted normally.

Structure
REQ-032 Shared package cle_pkg holds IMG_W=32, IMG_H=32, ADDR_W=10, LABEL_W=8, COUNT_W=11, the state enum, and the object-record struct (label, count, box).
REQ-033 One sub-module, label_table: MAX_OBJ-entry associative store with match, allocate and update ports, plus an indexed read port for EMIT.

Verification
REQ-034 All-zero SRAM, start -> no obj_valid, done=1 at cycle 1026, overflow=0.
REQ-035 Single label 0x05 filling rows 3..6, cols 10..20 -> one record: label 05, count 44, x 10..20, y 3..6.
REQ-036 Labels 0x09 at addr 0 and 0x02 at addr 1023 -> records in order 09 (count 1, box 0,0,0,0), then 02 (count 1, box 31,31,31,31).
REQ-037 Nine distinct single-pixel labels with MAX_OBJ=8 -> eight records, ninth dropped, overflow=1.
REQ-038 obj_ready held 0 for 5 cycles, then toggled -> obj_* stable while stalled, every record emitted exactly once.
REQ-039 reset pulsed at SCAN addr 500, then start -> fresh scan, results identical to an uninterrupted run.

Source files
------------

// File: rtl/cle_pkg.sv
// cle_pkg: shared image geometry, FSM states and object-record layout
// for the label statistics block.
package cle_pkg;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int ADDR_W = 10;
  localparam int LABEL_W = 8;
  localparam int COUNT_W = 11;
  localparam int COORD_W = 5;
  localparam int IDX_W = 4;
  localparam int NUM_W = IDX_W + 1;
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_TAIL, S_EMIT, S_DONE} state_t;
  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [COUNT_W-1:0] count;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } obj_t;
endpackage

// File: rtl/label_table.sv
// label_table: small associative store of per-label pixel count and bounding box,
// filled in first-seen order, with an indexed read port for emission.
module label_table
  import cle_pkg::*;
#(
  parameter int MAX_OBJ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               pix_valid,
  input  logic [LABEL_W-1:0] pix_label,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [IDX_W-1:0]   rd_idx,
  output obj_t               rd_obj,
  output logic [NUM_W-1:0]   n_used,
  output logic               alloc,
  output logic               drop
);
  obj_t ent [MAX_OBJ];
  logic hit;
  logic fresh;
  logic [IDX_W-1:0] hit_idx;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    rd_obj = '0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      if (NUM_W'(i) < n_used && ent[i].label == pix_label) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (IDX_W'(i) == rd_idx) rd_obj = ent[i];
    end
  end
  // label 0 is never allocated, so a hit already implies a foreground pixel
  assign fresh = pix_valid && pix_label != '0 && !hit;
  assign alloc = fresh && n_used < NUM_W'(MAX_OBJ);
  assign drop = fresh && !alloc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_used <= '0;
      for (int i = 0; i < MAX_OBJ; i++) ent[i] <= '0;
    end else if (clear) begin
      n_used <= '0;
    end else begin
      if (alloc) n_used <= n_used + 1'b1;
      for (int i = 0; i < MAX_OBJ; i++) begin
        if (pix_valid && hit && hit_idx == IDX_W'(i)) begin
          ent[i].count <= ent[i].count + 1'b1;
          ent[i].xmin <= pix_x < ent[i].xmin ? pix_x : ent[i].xmin;
          ent[i].xmax <= pix_x > ent[i].xmax ? pix_x : ent[i].xmax;
          ent[i].ymin <= pix_y < ent[i].ymin ? pix_y : ent[i].ymin;
          ent[i].ymax <= pix_y > ent[i].ymax ? pix_y : ent[i].ymax;
        end else if (alloc && n_used == NUM_W'(i)) begin
          ent[i] <= '{label: pix_label, count: COUNT_W'(1), xmin: pix_x, xmax: pix_x, ymin: pix_y, ymax: pix_y};
        end
      end
    end
  end
endmodule

// File: rtl/label_stats.sv
// label_stats: scans a 32x32 label SRAM once per start, accumulates per-label
// count and bounding box, then streams one record per label over valid/ready.
module label_stats
  import cle_pkg::*;
#(
  parameter int MAX_OBJ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  sram_a,
  input  logic [LABEL_W-1:0] sram_q,
  output logic               obj_valid,
  input  logic               obj_ready,
  output logic [LABEL_W-1:0] obj_label,
  output logic [COUNT_W-1:0] obj_count,
  output logic [COORD_W-1:0] obj_xmin,
  output logic [COORD_W-1:0] obj_xmax,
  output logic [COORD_W-1:0] obj_ymin,
  output logic [COORD_W-1:0] obj_ymax,
  output logic               busy,
  output logic               done,
  output logic               overflow
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_d;
  logic pix_valid;
  logic [IDX_W-1:0] emit_idx;
  logic [NUM_W-1:0] n_used;
  logic alloc, drop, accept, last_rec;
  obj_t rd_obj;
  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last_rec = NUM_W'(emit_idx) + 1'b1 == n_used;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = accept ? S_SCAN : state;
      S_SCAN: state_n = sram_a == LAST ? S_TAIL : S_SCAN;
      S_TAIL: state_n = (n_used != '0 || alloc) ? S_EMIT : S_DONE;
      S_EMIT: state_n = obj_ready && last_rec ? S_DONE : S_EMIT;
      default: state_n = S_IDLE;
    endcase
  end
  assign obj_valid = state == S_EMIT;
  assign busy = state == S_SCAN || state == S_TAIL || state == S_EMIT;
  assign done = state == S_DONE;
  assign {obj_label, obj_count, obj_xmin, obj_xmax, obj_ymin, obj_ymax} = obj_valid ? rd_obj : '0;
  // read data lags the address by one cycle, so addr_d/pix_valid tag each returned label
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      sram_a <= '0;
      addr_d <= '0;
      pix_valid <= 1'b0;
      emit_idx <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      addr_d <= sram_a;
      pix_valid <= state == S_SCAN;
      sram_a <= accept ? '0 : (state == S_SCAN && sram_a != LAST) ? sram_a + 1'b1 : sram_a;
      emit_idx <= accept ? '0 : (obj_valid && obj_ready) ? emit_idx + 1'b1 : emit_idx;
      overflow <= accept ? 1'b0 : overflow | drop;
    end
  end
  label_table #(.MAX_OBJ(MAX_OBJ)) u_table (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .pix_valid(pix_valid),
    .pix_label(sram_q),
    .pix_x(addr_d[4:0]),
    .pix_y(addr_d[9:5]),
    .rd_idx(emit_idx),
    .rd_obj(rd_obj),
    .n_used(n_used),
    .alloc(alloc),
    .drop(drop)
  );
endmodule

// File: tb/tb_label_stats.sv
// tb_label_stats: directed scans of hand-built label images against a table
// of hand-computed object records.
module tb_label_stats;
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [9:0] sram_a;
  logic [7:0] sram_q;
  logic obj_valid, obj_ready;
  logic [7:0] obj_label;
  logic [10:0] obj_count;
  logic [4:0] obj_xmin, obj_xmax, obj_ymin, obj_ymax;
  logic busy, done, overflow;
  logic [7:0] mem [1024];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int scen;
    int label;
    int count;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
  } rec_t;
  rec_t tab[$];

  label_stats #(.MAX_OBJ(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sram_a(sram_a), .sram_q(sram_q),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_label(obj_label),
    .obj_count(obj_count), .obj_xmin(obj_xmin), .obj_xmax(obj_xmax),
    .obj_ymin(obj_ymin), .obj_ymax(obj_ymax), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sram_q <= mem[sram_a];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int scen);
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    case (scen)
      1: for (int r = 3; r <= 6; r++) for (int c = 10; c <= 20; c++) mem[r*32+c] = 8'h05;
      2: begin mem[0] = 8'h09; mem[1023] = 8'h02; end
      3: for (int k = 1; k <= 9; k++) mem[37*k] = 8'(k);
      4: begin
        mem[84] = 8'h30; mem[97] = 8'h31; mem[164] = 8'h30;
        mem[300] = 8'h30; mem[301] = 8'h30; mem[302] = 8'h31;
      end
      default: ;
    endcase
  endtask

  task automatic run_scan(input int scen, input bit stall, input bit stray, input int exp_ovf);
    rec_t got[$];
    rec_t ex[$];
    int c;
    foreach (tab[i]) if (tab[i].scen == scen) ex.push_back(tab[i]);
    obj_ready = !stall;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 1;
    chk($sformatf("s%0d_busy_c1", scen), busy, 1);
    chk($sformatf("s%0d_addr_c1", scen), sram_a, 0);
    while (!(obj_valid || done) && c < 2000) begin
      @(negedge clk);
      c++;
      if (stray && c == 300) start = 1'b1;
      if (c == 301) start = 1'b0;
    end
    chk($sformatf("s%0d_latency", scen), c, 1026);
    for (int t = 0; t < 300 && !done; t++) begin
      obj_ready = stall ? (t >= 5 && t[0]) : 1'b1;
      if (stall && t < 5 && ex.size() > 0) begin
        chk($sformatf("s%0d_stall%0d_valid", scen, t), obj_valid, 1);
        chk($sformatf("s%0d_stall%0d_label", scen, t), obj_label, ex[0].label);
        chk($sformatf("s%0d_stall%0d_xmin", scen, t), obj_xmin, ex[0].xmin);
      end
      if (obj_valid && obj_ready)
        got.push_back('{scen, obj_label, obj_count, obj_xmin, obj_xmax, obj_ymin, obj_ymax});
      @(negedge clk);
    end
    obj_ready = 1'b0;
    chk($sformatf("s%0d_done", scen), done, 1);
    chk($sformatf("s%0d_busy_end", scen), busy, 0);
    chk($sformatf("s%0d_valid_end", scen), obj_valid, 0);
    chk($sformatf("s%0d_overflow", scen), overflow, exp_ovf);
    chk($sformatf("s%0d_nrec", scen), got.size(), ex.size());
    for (int i = 0; i < ex.size() && i < got.size(); i++) begin
      chk($sformatf("s%0d_r%0d_label", scen, i), got[i].label, ex[i].label);
      chk($sformatf("s%0d_r%0d_count", scen, i), got[i].count, ex[i].count);
      chk($sformatf("s%0d_r%0d_xmin", scen, i), got[i].xmin, ex[i].xmin);
      chk($sformatf("s%0d_r%0d_xmax", scen, i), got[i].xmax, ex[i].xmax);
      chk($sformatf("s%0d_r%0d_ymin", scen, i), got[i].ymin, ex[i].ymin);
      chk($sformatf("s%0d_r%0d_ymax", scen, i), got[i].ymax, ex[i].ymax);
    end
  endtask

  initial begin
    int bad_cycles;
    tab.push_back('{1, 'h05, 44, 10, 20, 3, 6});
    tab.push_back('{2, 'h09, 1, 0, 0, 0, 0});
    tab.push_back('{2, 'h02, 1, 31, 31, 31, 31});
    tab.push_back('{3, 1, 1, 5, 5, 1, 1});
    tab.push_back('{3, 2, 1, 10, 10, 2, 2});
    tab.push_back('{3, 3, 1, 15, 15, 3, 3});
    tab.push_back('{3, 4, 1, 20, 20, 4, 4});
    tab.push_back('{3, 5, 1, 25, 25, 5, 5});
    tab.push_back('{3, 6, 1, 30, 30, 6, 6});
    tab.push_back('{3, 7, 1, 3, 3, 8, 8});
    tab.push_back('{3, 8, 1, 8, 8, 9, 9});
    tab.push_back('{4, 'h30, 4, 4, 20, 2, 9});
    tab.push_back('{4, 'h31, 2, 1, 14, 3, 9});
    reset = 1'b0;
    start = 1'b0;
    obj_ready = 1'b0;
    load(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", obj_valid, 0);
    chk("rst_addr", sram_a, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", obj_count, 0);
    reset = 1'b1;
    @(negedge clk);
    run_scan(0, 1'b0, 1'b0, 0);
    load(1); run_scan(1, 1'b0, 1'b0, 0);
    load(2); run_scan(2, 1'b0, 1'b0, 0);
    load(3); run_scan(3, 1'b1, 1'b0, 1);
    load(4); run_scan(4, 1'b0, 1'b1, 0);
    // abort a scan part way through, then rerun the same image
    load(1);
    obj_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int t = 0; t < 2000 && sram_a != 10'd500; t++) @(negedge clk);
    chk("abort_addr500", sram_a, 500);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_addr", sram_a, 0);
    chk("abort_valid", obj_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clk) reset = 1'b1;
    bad_cycles = 0;
    repeat (1100) begin
      @(negedge clk);
      if (obj_valid || done || busy) bad_cycles++;
    end
    chk("abort_idle_after_release", bad_cycles, 0);
    run_scan(1, 1'b0, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
